// File: rtl/blk_965656_pkg.sv
// Shared definitions for the intest EDT/scan bidirectional-pad test data register.
package blk_965656_pkg;

    // Default register geometry.
    localparam int unsigned TDR_LENGTH    = 8;
    localparam int unsigned TDR_STAT_W    = 2;
    localparam logic [7:0]  TDR_RESET_VAL = 8'h00;

    // Field positions within the captured word: status at the bottom,
    // the sticky error flag just above it, control bits above that.
    localparam int unsigned STAT_LSB = 0;
    localparam int unsigned ERR_BIT  = TDR_STAT_W;
    localparam int unsigned CTRL_LSB = TDR_STAT_W + 1;

    // Counter must hold 0..len+1, where len+1 is the "unarmed / overrun" value.
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 2);
    endfunction

endpackage

// File: rtl/blk_965656_len_chk.sv
// Shift-length checker: counts shifts since the last capture and flags
// when exactly LENGTH shifts have happened, so an update can be trusted.
module blk_965656_len_chk
    import blk_965656_pkg::*;
#(
    parameter int unsigned LENGTH    = TDR_LENGTH,
    parameter bit          CHECK_LEN = 1'b1
) (
    input  logic tck,
    input  logic rst_n,
    input  logic sel,
    input  logic ce,
    input  logic se,
    output logic len_ok
);

    localparam int unsigned     CNT_W   = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LENGTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             len_ok_r;
    logic             len_ok_nxt_s;

    // Next count: capture clears, shift increments up to saturation, otherwise hold.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (sel && ce) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (sel && se) begin
            if (cnt_r == CNT_SAT) begin
                cnt_nxt_s = cnt_r;
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Length verdict, precomputed from the next count so it is a register output.
    always_comb begin
        len_ok_nxt_s = 1'b0;
        if (CHECK_LEN == 1'b0) begin
            len_ok_nxt_s = 1'b1;
        end else begin
            len_ok_nxt_s = (cnt_nxt_s == CNT_TGT);
        end
    end

    // Counter and verdict registers; reset leaves the checker unarmed.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= CNT_SAT;
            len_ok_r <= (CHECK_LEN == 1'b0);
        end else begin
            cnt_r    <= cnt_nxt_s;
            len_ok_r <= len_ok_nxt_s;
        end
    end

    assign len_ok = len_ok_r;

endmodule

// File: rtl/blk_965656.sv
// IJTAG TDR holding the intest control bits for EDT/scan bidirectional pads.
// Captures core status and the sticky update error; updates are gated by
// the shift-length checker so a short or long scan cannot corrupt ctrl_out.
module blk_965656
    import blk_965656_pkg::*;
#(
    parameter int unsigned       LENGTH    = TDR_LENGTH,
    parameter int unsigned       STAT_W    = TDR_STAT_W,
    parameter logic [LENGTH-1:0] RESET_VAL = LENGTH'(TDR_RESET_VAL),
    parameter bit                CHECK_LEN = 1'b1
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_si,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    output logic              ijtag_so,
    input  logic [STAT_W-1:0] status_in,
    output logic [LENGTH-1:0] ctrl_out,
    output logic              update_error
);

    logic [LENGTH-1:0] sr_r;
    logic [LENGTH-1:0] sr_nxt_s;
    logic [LENGTH-1:0] capture_s;
    logic [LENGTH-1:0] ctrl_r;
    logic              err_r;
    logic              so_r;
    logic              len_ok_s;

    // Captured word: upper control bits, error flag, then fresh core status.
    assign capture_s = {ctrl_r[LENGTH-1:STAT_W+1], err_r, status_in};

    // Shift-register next state: capture beats shift, deselected holds.
    always_comb begin
        sr_nxt_s = sr_r;
        if (ijtag_sel && ijtag_ce) begin
            sr_nxt_s = capture_s;
        end else if (ijtag_sel && ijtag_se) begin
            sr_nxt_s = {ijtag_si, sr_r[LENGTH-1:1]};
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // Shift register state on the rising TCK edge.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr_r <= '0;
        end else begin
            sr_r <= sr_nxt_s;
        end
    end

    // Retiming latch: open while TCK is low so SO moves half a cycle after the shift.
    always_latch begin
        if (!ijtag_reset) begin
            so_r <= 1'b0;
        end else if (!ijtag_tck) begin
            so_r <= sr_r[0];
        end
    end

    // Update stage on the falling TCK edge: apply only length-checked scans.
    always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            ctrl_r <= RESET_VAL;
            err_r  <= 1'b0;
        end else if (ijtag_ue && ijtag_sel) begin
            if (len_ok_s) begin
                ctrl_r <= sr_r;
            end else begin
                err_r  <= 1'b1;
            end
        end else begin
            ctrl_r <= ctrl_r;
            err_r  <= err_r;
        end
    end

    blk_965656_len_chk #(
        .LENGTH    (LENGTH),
        .CHECK_LEN (CHECK_LEN)
    ) u_len_chk (
        .tck    (ijtag_tck),
        .rst_n  (ijtag_reset),
        .sel    (ijtag_sel),
        .ce     (ijtag_ce),
        .se     (ijtag_se),
        .len_ok (len_ok_s)
    );

    assign ijtag_so     = so_r;
    assign ctrl_out     = ctrl_r;
    assign update_error = err_r;

endmodule

// File: tb/tb_blk_965656.sv
// Directed bench for the intest TDR: one instance with length checking,
// one without, driven by the same scan stimulus.
module tb_blk_965656;

    logic       tck = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       si;
    logic       ce;
    logic       se;
    logic       ue;
    logic [1:0] status;

    logic       so_a;
    logic [7:0] ctrl_a;
    logic       err_a;
    logic       so_b;
    logic [7:0] ctrl_b;
    logic       err_b;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] word;
    logic [7:0] cap;
    logic       exp_prev;
    logic       exp_new;

    always #5 tck = ~tck;

    blk_965656 dut_a (
        .ijtag_tck    (tck),
        .ijtag_reset  (rst_n),
        .ijtag_sel    (sel),
        .ijtag_si     (si),
        .ijtag_ce     (ce),
        .ijtag_se     (se),
        .ijtag_ue     (ue),
        .ijtag_so     (so_a),
        .status_in    (status),
        .ctrl_out     (ctrl_a),
        .update_error (err_a)
    );

    blk_965656 #(.CHECK_LEN(1'b0)) dut_b (
        .ijtag_tck    (tck),
        .ijtag_reset  (rst_n),
        .ijtag_sel    (sel),
        .ijtag_si     (si),
        .ijtag_ce     (ce),
        .ijtag_se     (se),
        .ijtag_ue     (ue),
        .ijtag_so     (so_b),
        .status_in    (status),
        .ctrl_out     (ctrl_b),
        .update_error (err_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: inputs stable over posedge and the following negedge,
    // returns 1 time unit after the negedge.
    task automatic step(input logic c, input logic s, input logic u, input logic d);
        ce = c;
        se = s;
        ue = u;
        si = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        ce = 1'b0;
        se = 1'b0;
        ue = 1'b0;
        #1;
        check("rst_ctrl_a", ctrl_a, 8'h00);
        check("rst_err_a", {7'd0, err_a}, 8'h00);
        check("rst_so_a", {7'd0, so_a}, 8'h00);
        check("rst_ctrl_b", ctrl_b, 8'h00);
        @(negedge tck);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        sel    = 1'b1;
        ce     = 1'b0;
        se     = 1'b0;
        ue     = 1'b0;
        si     = 1'b0;
        status = 2'b10;
        #1;
        reset_pulse();

        // 1: update before any capture
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_ctrl_a", ctrl_a, 8'h00);
        check("t1_err_a", {7'd0, err_a}, 8'h01);
        check("t1_ctrl_b", ctrl_b, 8'h00);
        check("t1_err_b", {7'd0, err_b}, 8'h00);

        // 2: capture 8'h02, shift in A5 LSB first, update
        reset_pulse();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_so_cap", {7'd0, so_a}, 8'h00);
        cap      = 8'h02;
        word     = 8'hA5;
        exp_prev = cap[0];
        for (int i = 0; i < 8; i++) begin
            ce = 1'b0;
            se = 1'b1;
            ue = 1'b0;
            si = word[i];
            @(posedge tck);
            #1;
            check("t2_so_hold", {7'd0, so_a}, {7'd0, exp_prev});
            @(negedge tck);
            #1;
            exp_new = (i < 7) ? cap[i+1] : word[0];
            check("t2_so", {7'd0, so_a}, {7'd0, exp_new});
            exp_prev = exp_new;
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t2_ctrl_a", ctrl_a, 8'hA5);
        check("t2_err_a", {7'd0, err_a}, 8'h00);
        check("t2_ctrl_b", ctrl_b, 8'hA5);

        // 3: short scan (7 shifts) is rejected; error then visible in capture
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_so_cap", {7'd0, so_a}, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("t3_so_7", {7'd0, so_a}, 8'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_ctrl_a", ctrl_a, 8'hA5);
        check("t3_err_a", {7'd0, err_a}, 8'h01);
        check("t3_ctrl_b", ctrl_b, 8'hFF);
        check("t3_err_b", {7'd0, err_b}, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_errbit_a", {7'd0, so_a}, 8'h01);
        check("t3_errbit_b", {7'd0, so_b}, 8'h00);

        // 4: long scan (9 shifts) is rejected with checking, applied without
        reset_pulse();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_ctrl_a", ctrl_a, 8'h00);
        check("t4_err_a", {7'd0, err_a}, 8'h01);
        check("t4_ctrl_b", ctrl_b, 8'hFF);
        check("t4_err_b", {7'd0, err_b}, 8'h00);

        // 5: deselected cycles with ce/se/ue high must not disturb anything
        step(1'b1, 1'b0, 1'b0, 1'b0);
        word = 8'h5B;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, word[i]);
        check("t5_so_pre", {7'd0, so_a}, 8'h01);
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, i[0]);
            check("t5_so_hold", {7'd0, so_a}, 8'h01);
            check("t5_ctrl_hold_a", ctrl_a, 8'h00);
            check("t5_ctrl_hold_b", ctrl_b, 8'hFF);
        end
        sel = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_ctrl_a", ctrl_a, 8'h5B);
        check("t5_err_a", {7'd0, err_a}, 8'h01);
        check("t5_ctrl_b", ctrl_b, 8'h5B);

        // 6: reset mid-shift, then a clean scan with simultaneous ce/se capture
        status = 2'b01;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset_pulse();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_cap_wins", {7'd0, so_a}, 8'h01);
        word = 8'hC3;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, word[i]);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_ctrl_a", ctrl_a, 8'hC3);
        check("t6_err_a", {7'd0, err_a}, 8'h00);
        check("t6_ctrl_b", ctrl_b, 8'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
